// File: rtl/param_update_seq_pkg.sv
// param_update_seq_pkg: shared state type and sel/ctrl codes for the parameter-memory bus.
package param_update_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, WAIT_DELTA, UPD_W1, UPD_B1, UPD_W2, UPD_B2, SYNC, DONE, ABORT
  } state_t;
  localparam logic [3:0] SEL_W1    = 4'b1100;
  localparam logic [3:0] SEL_B1    = 4'b1101;
  localparam logic [3:0] SEL_W2    = 4'b1110;
  localparam logic [3:0] SEL_B2    = 4'b1111;
  localparam logic [3:0] SEL_NONE  = 4'b0000;
  localparam logic [3:0] CTRL_WR   = 4'b1111;
  localparam logic [3:0] CTRL_IDLE = 4'b0000;
endpackage

// File: rtl/param_update_seq.sv
// param_update_seq: sequences w1/b1/w2/b2 writes of a training step, with delta timeout and periodic target sync.
module param_update_seq
  import param_update_seq_pkg::*;
#(
  parameter int SYNC_PERIOD = 4,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             delta_valid,
  input  logic             sync_ack,
  output logic [3:0]       sel,
  output logic [3:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             sync_req,
  output logic [CNT_W-1:0] update_count
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int SW = SYNC_PERIOD > 1 ? $clog2(SYNC_PERIOD) : 1;
  state_t           state, state_nx;
  logic [TW-1:0]    tcnt, tcnt_nx;
  logic [SW-1:0]    scnt, scnt_nx;
  logic [CNT_W-1:0] cnt_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      scnt         <= '0;
      update_count <= '0;
    end else begin
      state        <= state_nx;
      tcnt         <= tcnt_nx;
      scnt         <= scnt_nx;
      update_count <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    scnt_nx  = scnt;
    cnt_nx   = update_count;
    case (state)
      IDLE: begin
        tcnt_nx  = '0;
        state_nx = start ? WAIT_DELTA : IDLE;
      end
      WAIT_DELTA: begin
        // a delta arriving in the last allowed cycle still beats the timeout
        if (delta_valid) state_nx = UPD_W1;
        else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) state_nx = ABORT;
        else tcnt_nx = tcnt + TW'(1);
      end
      UPD_W1: state_nx = UPD_B1;
      UPD_B1: state_nx = UPD_W2;
      UPD_W2: state_nx = UPD_B2;
      UPD_B2: begin
        cnt_nx   = update_count + CNT_W'(1);
        state_nx = scnt == SW'(SYNC_PERIOD - 1) ? SYNC : DONE;
        scnt_nx  = scnt == SW'(SYNC_PERIOD - 1) ? '0 : scnt + SW'(1);
      end
      SYNC:    state_nx = sync_ack ? DONE : SYNC;
      default: state_nx = IDLE;
    endcase
  end
  assign sel = state == UPD_W1 ? SEL_W1 :
               state == UPD_B1 ? SEL_B1 :
               state == UPD_W2 ? SEL_W2 :
               state == UPD_B2 ? SEL_B2 : SEL_NONE;
  assign ctrl     = state inside {UPD_W1, UPD_B1, UPD_W2, UPD_B2} ? CTRL_WR : CTRL_IDLE;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign abort    = state == ABORT;
  assign sync_req = state == SYNC;
endmodule
